// File: rtl/dds_phase_addr_gen.sv
// dds_phase_addr_gen: drives the single-port waveform RAM of the DDS chain.
// LOAD fills the table from a valid/ready stream; RUN turns a phase
// accumulator into read addresses; sample_valid flags cycles where RAM dout
// carries a DDS sample (RAM read latency of one cycle).
module dds_phase_addr_gen #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int PHASE_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_start,
   input  logic                   ld_valid,
   input  logic [DATA_WIDTH-1:0]  ld_data,
   output logic                   ld_ready,
   input  logic                   run_en,
   input  logic [PHASE_WIDTH-1:0] fcw,
   input  logic [ADDR_WIDTH-1:0]  pofs,
   output logic                   ram_wrn,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [DATA_WIDTH-1:0]  ram_din,
   output logic                   loaded,
   output logic                   busy,
   output logic                   sample_valid
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                 state_reg, state_next;
   logic [PHASE_WIDTH-1:0] acc_reg, acc_next;
   logic [ADDR_WIDTH-1:0]  wr_cnt_reg, wr_cnt_next;
   logic                   issue_v_reg, issue_v_next;
   logic                   loaded_reg, loaded_next;
   logic                   ram_wrn_reg, ram_wrn_next;
   logic [ADDR_WIDTH-1:0]  ram_addr_reg, ram_addr_next;
   logic [DATA_WIDTH-1:0]  ram_din_reg, ram_din_next;
   logic                   ld_ready_reg;
   logic                   busy_reg;
   logic                   sample_valid_reg;

   logic                   beat;
   logic                   do_issue;
   logic [ADDR_WIDTH-1:0]  phase_addr;

   // Top ADDR_WIDTH phase bits plus offset, wrapping in the table.
   assign phase_addr = acc_reg[PHASE_WIDTH-1 -: ADDR_WIDTH] + pofs;
   // ld_ready_reg is only high while in LOAD, so this is an accepted beat.
   assign beat = ld_valid && ld_ready_reg;

   // Next-state and next-output logic; holds everything by default.
   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      wr_cnt_next   = wr_cnt_reg;
      issue_v_next  = 1'b0;
      loaded_next   = loaded_reg;
      ram_wrn_next  = 1'b0;
      ram_addr_next = ram_addr_reg;
      ram_din_next  = ram_din_reg;
      do_issue      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (load_start) begin
               state_next  = ST_LOAD;
               wr_cnt_next = '0;
               loaded_next = 1'b0;
            end else if (run_en && loaded_reg) begin
               state_next = ST_RUN;
               do_issue   = 1'b1;
            end
         end
         ST_LOAD: begin
            if (beat) begin
               ram_wrn_next  = 1'b1;
               ram_addr_next = wr_cnt_reg;
               ram_din_next  = ld_data;
               wr_cnt_next   = wr_cnt_reg + ADDR_ONE;
               if (wr_cnt_reg == LAST_ADDR) begin
                  loaded_next = 1'b1;
                  state_next  = ST_IDLE;
               end
            end
         end
         ST_RUN: begin
            if (load_start) begin
               state_next  = ST_LOAD;
               acc_next    = '0;
               wr_cnt_next = '0;
               loaded_next = 1'b0;
            end else if (!run_en) begin
               // acc is kept so a later resume stays phase-continuous
               state_next = ST_IDLE;
            end else begin
               do_issue = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (do_issue) begin
         ram_addr_next = phase_addr;
         acc_next      = acc_reg + fcw;
         issue_v_next  = 1'b1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         acc_reg          <= '0;
         wr_cnt_reg       <= '0;
         issue_v_reg      <= 1'b0;
         loaded_reg       <= 1'b0;
         ram_wrn_reg      <= 1'b0;
         ram_addr_reg     <= '0;
         ram_din_reg      <= '0;
         ld_ready_reg     <= 1'b0;
         busy_reg         <= 1'b0;
         sample_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         acc_reg          <= acc_next;
         wr_cnt_reg       <= wr_cnt_next;
         issue_v_reg      <= issue_v_next;
         loaded_reg       <= loaded_next;
         ram_wrn_reg      <= ram_wrn_next;
         ram_addr_reg     <= ram_addr_next;
         ram_din_reg      <= ram_din_next;
         ld_ready_reg     <= (state_next == ST_LOAD);
         busy_reg         <= (state_next == ST_LOAD);
         sample_valid_reg <= issue_v_reg;
      end
   end

   assign ld_ready     = ld_ready_reg;
   assign ram_wrn      = ram_wrn_reg;
   assign ram_addr     = ram_addr_reg;
   assign ram_din      = ram_din_reg;
   assign loaded       = loaded_reg;
   assign busy         = busy_reg;
   assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// Scoreboard bench for dds_phase_addr_gen with a behavioural waveform RAM.
// Expected writes and reads are queued as stimulus is driven and checked
// when the DUT shows ram_wrn or sample_valid.
module tb_dds_phase_addr_gen;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          run_en;
   logic [PW-1:0] fcw;
   logic [AW-1:0] pofs;
   logic          ram_wrn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          loaded;
   logic          busy;
   logic          sample_valid;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] dout;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t wq[$];
   exp_t rq[$];
   exp_t mon_e;
   logic [AW-1:0] prev_addr = '0;

   int n_checks = 0;
   int n_errors = 0;

   dds_phase_addr_gen #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .PHASE_WIDTH(PW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .run_en      (run_en),
      .fcw         (fcw),
      .pofs        (pofs),
      .ram_wrn     (ram_wrn),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .loaded      (loaded),
      .busy        (busy),
      .sample_valid(sample_valid)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle registered read.
   always @(posedge clk) begin
      if (ram_wrn) mem[ram_addr] <= ram_din;
      dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT produces a write or a sample.
   always begin
      @(posedge clk);
      #1;
      if (ram_wrn) begin
         if (wq.size() == 0) begin
            check("wr_unexpected", {31'd0, ram_wrn}, 32'd0);
         end else begin
            mon_e = wq.pop_front();
            $display("WR addr=%0d din=%0d", ram_addr, ram_din);
            check("wr_addr", {28'd0, ram_addr}, {28'd0, mon_e.addr});
            check("wr_din", ram_din, mon_e.data);
         end
      end
      if (sample_valid) begin
         if (rq.size() == 0) begin
            check("rd_unexpected", {31'd0, sample_valid}, 32'd0);
         end else begin
            mon_e = rq.pop_front();
            $display("RD addr=%0d dout=%0d", prev_addr, dout);
            check("rd_addr", {28'd0, prev_addr}, {28'd0, mon_e.addr});
            check("rd_dout", dout, mon_e.data);
         end
      end
      prev_addr = ram_addr;
   end

   function automatic exp_t mk(input int a, input int d);
      exp_t e;
      e.addr = AW'(a);
      e.data = DW'(d);
      return e;
   endfunction

   // Called just after a negedge; runs a full 16-beat table load of i*i.
   task automatic do_load(input bit gapped);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      run_en     = 1'b0;
      check("load_busy", {31'd0, busy}, 32'd1);
      check("load_loaded_clr", {31'd0, loaded}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         check("load_ld_ready", {31'd0, ld_ready}, 32'd1);
         ld_valid = 1'b1;
         ld_data  = DW'(i * i);
         wq.push_back(mk(i, i * i));
         @(negedge clk);
         if (i == 0) check("load_sv_low", {31'd0, sample_valid}, 32'd0);
         if (gapped) begin
            ld_valid = 1'b0;
            ld_data  = 32'hDEAD_BEEF;
            @(negedge clk);
         end
      end
      ld_valid = 1'b0;
      check("load_done_loaded", {31'd0, loaded}, 32'd1);
      check("load_done_ready", {31'd0, ld_ready}, 32'd0);
      check("load_done_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("load_wq_drain", wq.size(), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wrn"}, {31'd0, ram_wrn}, 32'd0);
      check({tag, "_addr"}, {28'd0, ram_addr}, 32'd0);
      check({tag, "_din"}, ram_din, 32'd0);
      check({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
      check({tag, "_sv"}, {31'd0, sample_valid}, 32'd0);
   endtask

   initial begin
      int t5_addr [6];
      t5_addr = '{3, 4, 6, 7, 9, 10};

      rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
      run_en = 1'b0; fcw = '0; pofs = '0;

      // 1: reset, then run_en without a table
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      rst    = 1'b0;
      run_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_all_zero("noload_run");
      end
      run_en = 1'b0;
      @(negedge clk);

      // 2: continuous load, 3: gapped load
      do_load(1'b0);
      do_load(1'b1);

      // 4: run fcw=0x10 pofs=0, 17 issues wrapping the table
      fcw  = 8'h10;
      pofs = 4'd0;
      for (int i = 0; i < 17; i++) begin
         run_en = 1'b1;
         rq.push_back(mk(i % 16, (i % 16) * (i % 16)));
         @(negedge clk);
         if (i == 0) check("run_first_sv", {31'd0, sample_valid}, 32'd0);
         if (i == 1) check("run_second_sv", {31'd0, sample_valid}, 32'd1);
      end
      run_en = 1'b0;
      repeat (3) @(negedge clk);
      check("run_rq_drain", rq.size(), 32'd0);
      check("run_sv_off", {31'd0, sample_valid}, 32'd0);

      // 6b: resume (acc now 0x10 -> 1,2,3), then load_start while running
      for (int i = 1; i <= 3; i++) begin
         run_en = 1'b1;
         rq.push_back(mk(i, i * i));
         @(negedge clk);
      end
      do_load(1'b0);
      check("reload_rq_drain", rq.size(), 32'd0);

      // 5: fcw=0x18 pofs=3 from acc 0, one-cycle run_en drop after 4 issues
      fcw  = 8'h18;
      pofs = 4'd3;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin
            run_en = 1'b0;
            @(negedge clk);
         end
         run_en = 1'b1;
         rq.push_back(mk(t5_addr[k], t5_addr[k] * t5_addr[k]));
         @(negedge clk);
      end
      run_en = 1'b0;
      repeat (3) @(negedge clk);
      check("ofs_rq_drain", rq.size(), 32'd0);

      // 6a: reset after 5 load beats
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1'b1;
         ld_data  = DW'(100 + i);
         wq.push_back(mk(i, 100 + i));
         @(negedge clk);
      end
      rst     = 1'b1;
      ld_data = DW'(105);
      @(negedge clk);
      check("midrst_wrn", {31'd0, ram_wrn}, 32'd0);
      check("midrst_loaded", {31'd0, loaded}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_ready", {31'd0, ld_ready}, 32'd0);
      check("midrst_wq_drain", wq.size(), 32'd0);
      rst      = 1'b0;
      ld_valid = 1'b0;
      run_en   = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_norun_sv", {31'd0, sample_valid}, 32'd0);
      check("midrst_norun_loaded", {31'd0, loaded}, 32'd0);
      run_en = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
